// File: rtl/nonl_antilog_seq.sv
// nonl_antilog_seq: turns one packed vector of Q5.12 log2-magnitude terms back
// into signed linear fixed-point values. Terms are pushed one per cycle through
// a shared two-stage antilog datapath. The finished vector is returned over a
// valid/ready handshake.
module nonl_antilog_seq #(
    parameter int Q_ORD     = 7,
    parameter int LOG_WIDTH = 17,
    parameter int LOG_QP    = 12,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_QP    = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [Q_ORD*LOG_WIDTH-1:0]   log_in_packed,
    input  logic [Q_ORD-1:0]             sign_in_packed,
    input  logic [Q_ORD-1:0]             valid_in_packed,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [Q_ORD*OUT_WIDTH-1:0]   lin_out_packed,
    output logic [Q_ORD-1:0]             sat_packed
);

    // Exponent is the signed integer part of the log term; the mantissa carries
    // the hidden leading one.
    localparam int EXP_W  = LOG_WIDTH - LOG_QP;
    localparam int MANT_W = LOG_QP + 1;
    // Wide enough for the largest left shift of the mantissa with no loss and
    // for the rounding constant of the largest right shift.
    localparam int MAG_W  = MANT_W + (2 ** (EXP_W - 1));
    localparam int K_W    = $clog2(Q_ORD + 1);

    localparam logic [K_W-1:0]       K_END    = K_W'(Q_ORD);
    localparam logic [K_W-1:0]       K_LAST   = K_W'(Q_ORD - 1);
    localparam logic [MAG_W-1:0]     MAG_MAX  = MAG_W'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic [OUT_WIDTH-1:0] OUT_MAX  = OUT_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Unsigned magnitude of 2^(e + frac): left shift for e >= 0, rounded
    // (half up) right shift for e < 0.
    function automatic logic [MAG_W-1:0] antilog_mag(
        input logic [EXP_W-1:0]  e,
        input logic [MANT_W-1:0] m
    );
        logic [MAG_W-1:0] mw;
        logic [MAG_W-1:0] rnd;
        logic [EXP_W-1:0] sh;
        mw = MAG_W'(m);
        if (!e[EXP_W-1]) begin
            antilog_mag = mw << e;
        end else begin
            sh  = ~e + EXP_W'(1);
            rnd = MAG_W'(1) << (sh - EXP_W'(1));
            antilog_mag = (mw + rnd) >> sh;
        end
    endfunction

    state_t                       state_q,   state_d;
    logic [Q_ORD*LOG_WIDTH-1:0]   log_q,     log_d;
    logic [Q_ORD-1:0]             sign_q,    sign_d;
    logic [Q_ORD-1:0]             valid_q,   valid_d;
    logic [K_W-1:0]               k_q,       k_d;
    logic                         s1_vld_q,  s1_vld_d;
    logic [EXP_W-1:0]             s1_e_q,    s1_e_d;
    logic [MANT_W-1:0]            s1_m_q,    s1_m_d;
    logic                         s1_sign_q, s1_sign_d;
    logic                         s1_tv_q,   s1_tv_d;
    logic [K_W-1:0]               s1_idx_q,  s1_idx_d;
    logic [Q_ORD*OUT_WIDTH-1:0]   lin_q,     lin_d;
    logic [Q_ORD-1:0]             sat_q,     sat_d;

    logic [MAG_W-1:0]             mag_s;
    logic [OUT_WIDTH-1:0]         lane_mag_s;
    logic [OUT_WIDTH-1:0]         lane_val_s;
    logic                         lane_sat_s;

    assign in_ready       = (state_q == ST_IDLE);
    assign out_valid      = (state_q == ST_DONE);
    assign lin_out_packed = lin_q;
    assign sat_packed     = sat_q;

    // Stage 2: magnitude, saturation, sign and term-valid masking of the term held in stage 1.
    always_comb begin
        mag_s      = antilog_mag(s1_e_q, s1_m_q);
        lane_mag_s = {OUT_WIDTH{1'b0}};
        lane_sat_s = 1'b0;
        if (!s1_tv_q) begin
            lane_mag_s = {OUT_WIDTH{1'b0}};
            lane_sat_s = 1'b0;
        end else if (mag_s > MAG_MAX) begin
            lane_mag_s = OUT_MAX;
            lane_sat_s = 1'b1;
        end else begin
            lane_mag_s = mag_s[OUT_WIDTH-1:0];
            lane_sat_s = 1'b0;
        end
        if (s1_sign_q) begin
            lane_val_s = ~lane_mag_s + OUT_WIDTH'(1);
        end else begin
            lane_val_s = lane_mag_s;
        end
    end

    // Next-state logic: handshake FSM, term issue into stage 1, lane write-back from stage 2.
    always_comb begin
        state_d   = state_q;
        log_d     = log_q;
        sign_d    = sign_q;
        valid_d   = valid_q;
        k_d       = k_q;
        s1_vld_d  = s1_vld_q;
        s1_e_d    = s1_e_q;
        s1_m_d    = s1_m_q;
        s1_sign_d = s1_sign_q;
        s1_tv_d   = s1_tv_q;
        s1_idx_d  = s1_idx_q;
        lin_d     = lin_q;
        sat_d     = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    log_d    = log_in_packed;
                    sign_d   = sign_in_packed;
                    valid_d  = valid_in_packed;
                    k_d      = {K_W{1'b0}};
                    s1_vld_d = 1'b0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (k_q != K_END) begin
                    s1_vld_d  = 1'b1;
                    s1_e_d    = log_q[k_q*LOG_WIDTH + LOG_QP +: EXP_W];
                    s1_m_d    = {1'b1, log_q[k_q*LOG_WIDTH +: LOG_QP]};
                    s1_sign_d = sign_q[k_q];
                    s1_tv_d   = valid_q[k_q];
                    s1_idx_d  = k_q;
                    k_d       = k_q + K_W'(1);
                end else begin
                    s1_vld_d  = 1'b0;
                end
                if (s1_vld_q) begin
                    lin_d[s1_idx_q*OUT_WIDTH +: OUT_WIDTH] = lane_val_s;
                    sat_d[s1_idx_q] = lane_sat_s;
                    if (s1_idx_q == K_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                k_d      = {K_W{1'b0}};
                s1_vld_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial vector and clears the outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            log_q     <= {(Q_ORD*LOG_WIDTH){1'b0}};
            sign_q    <= {Q_ORD{1'b0}};
            valid_q   <= {Q_ORD{1'b0}};
            k_q       <= {K_W{1'b0}};
            s1_vld_q  <= 1'b0;
            s1_e_q    <= {EXP_W{1'b0}};
            s1_m_q    <= {MANT_W{1'b0}};
            s1_sign_q <= 1'b0;
            s1_tv_q   <= 1'b0;
            s1_idx_q  <= {K_W{1'b0}};
            lin_q     <= {(Q_ORD*OUT_WIDTH){1'b0}};
            sat_q     <= {Q_ORD{1'b0}};
        end else begin
            state_q   <= state_d;
            log_q     <= log_d;
            sign_q    <= sign_d;
            valid_q   <= valid_d;
            k_q       <= k_d;
            s1_vld_q  <= s1_vld_d;
            s1_e_q    <= s1_e_d;
            s1_m_q    <= s1_m_d;
            s1_sign_q <= s1_sign_d;
            s1_tv_q   <= s1_tv_d;
            s1_idx_q  <= s1_idx_d;
            lin_q     <= lin_d;
            sat_q     <= sat_d;
        end
    end

endmodule

// File: tb/tb_nonl_antilog_seq.sv
// Directed testbench for nonl_antilog_seq: lane conversions, saturation,
// valid masking, handshake stall/release, latency and mid-run reset.
module tb_nonl_antilog_seq;

    localparam int Q  = 7;
    localparam int LW = 17;
    localparam int OW = 16;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [Q*LW-1:0]   log_in_packed;
    logic [Q-1:0]      sign_in_packed;
    logic [Q-1:0]      valid_in_packed;
    logic              out_valid;
    logic              out_ready;
    logic [Q*OW-1:0]   lin_out_packed;
    logic [Q-1:0]      sat_packed;

    int n_cmp;
    int n_err;

    logic [LW-1:0] l_arr   [Q];
    logic [Q-1:0]  s_vec;
    logic [Q-1:0]  v_vec;
    logic [OW-1:0] exp_lin [Q];
    logic [Q-1:0]  exp_sat;

    nonl_antilog_seq #(
        .Q_ORD(7), .LOG_WIDTH(17), .LOG_QP(12), .OUT_WIDTH(16), .OUT_QP(12)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .log_in_packed(log_in_packed),
        .sign_in_packed(sign_in_packed),
        .valid_in_packed(valid_in_packed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .lin_out_packed(lin_out_packed),
        .sat_packed(sat_packed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector A: positive terms covering shifts, rounding, underflow, saturation, invalid lane.
    task automatic set_vec_a();
        l_arr[0] = 17'h00000; exp_lin[0] = 16'h1000;
        l_arr[1] = 17'h01800; exp_lin[1] = 16'h3000;
        l_arr[2] = 17'h1F000; exp_lin[2] = 16'h0800;
        l_arr[3] = 17'h13000; exp_lin[3] = 16'h0001;
        l_arr[4] = 17'h10FFF; exp_lin[4] = 16'h0000;
        l_arr[5] = 17'h03FFF; exp_lin[5] = 16'h7FFF;
        l_arr[6] = 17'h05555; exp_lin[6] = 16'h0000;
        s_vec   = 7'b1000000;
        v_vec   = 7'b0111111;
        exp_sat = 7'b0100000;
    endtask

    // Vector B: same terms with negative signs on lanes 0, 2, 4, 5.
    task automatic set_vec_b();
        set_vec_a();
        s_vec      = 7'b1110101;
        exp_lin[0] = 16'hF000;
        exp_lin[2] = 16'hF800;
        exp_lin[4] = 16'h0000;
        exp_lin[5] = 16'h8001;
    endtask

    // Vector C: every term invalid, large magnitudes and negative signs.
    task automatic set_vec_c();
        for (int k = 0; k < Q; k++) begin
            l_arr[k]   = 17'h03FFF;
            exp_lin[k] = 16'h0000;
        end
        s_vec   = 7'b1111111;
        v_vec   = 7'b0000000;
        exp_sat = 7'b0000000;
    endtask

    // Vector D: half-up rounding, just-below and just-above saturation.
    task automatic set_vec_d();
        l_arr[0] = 17'h02000; exp_lin[0] = 16'h4000;
        l_arr[1] = 17'h1E800; exp_lin[1] = 16'hFA00;
        l_arr[2] = 17'h1C001; exp_lin[2] = 16'h0100;
        l_arr[3] = 17'h1F001; exp_lin[3] = 16'h0801;
        l_arr[4] = 17'h02FFF; exp_lin[4] = 16'h7FFC;
        l_arr[5] = 17'h03000; exp_lin[5] = 16'h7FFF;
        l_arr[6] = 17'h1A000; exp_lin[6] = 16'h0040;
        s_vec   = 7'b0000010;
        v_vec   = 7'b1111111;
        exp_sat = 7'b0100000;
    endtask

    task automatic apply_buses();
        for (int k = 0; k < Q; k++) log_in_packed[k*LW +: LW] = l_arr[k];
        sign_in_packed  = s_vec;
        valid_in_packed = v_vec;
    endtask

    // Waits for in_ready, presents the current vector for one accept edge.
    task automatic launch();
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        apply_buses();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (lin_out_packed !== {(Q*OW){1'b0}}) begin n_err++; $display("FAIL rst_lin: got %h want 0", lin_out_packed); end
        n_cmp++; if (sat_packed !== 7'b0000000) begin n_err++; $display("FAIL rst_sat: got %b want 0", sat_packed); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_positive_terms();
        int lat;
        set_vec_a();
        launch();
        wait_done(lat);
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL pos_latency: got %0d want 8", lat); end
        for (int k = 0; k < Q; k++) begin
            n_cmp++;
            if (lin_out_packed[k*OW +: OW] !== exp_lin[k] || sat_packed[k] !== exp_sat[k]) begin
                n_err++;
                $display("FAIL pos_lane%0d: got lin=%h sat=%b want lin=%h sat=%b", k, lin_out_packed[k*OW +: OW], sat_packed[k], exp_lin[k], exp_sat[k]);
            end
        end
        release_out();
    endtask

    task automatic test_negative_terms();
        int lat;
        set_vec_b();
        launch();
        wait_done(lat);
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL neg_latency: got %0d want 8", lat); end
        for (int k = 0; k < Q; k++) begin
            n_cmp++;
            if (lin_out_packed[k*OW +: OW] !== exp_lin[k] || sat_packed[k] !== exp_sat[k]) begin
                n_err++;
                $display("FAIL neg_lane%0d: got lin=%h sat=%b want lin=%h sat=%b", k, lin_out_packed[k*OW +: OW], sat_packed[k], exp_lin[k], exp_sat[k]);
            end
        end
        release_out();
    endtask

    task automatic test_all_invalid();
        int lat;
        set_vec_c();
        launch();
        wait_done(lat);
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL inv_latency: got %0d want 8", lat); end
        n_cmp++; if (lin_out_packed !== {(Q*OW){1'b0}}) begin n_err++; $display("FAIL inv_lin: got %h want 0", lin_out_packed); end
        n_cmp++; if (sat_packed !== 7'b0000000) begin n_err++; $display("FAIL inv_sat: got %b want 0", sat_packed); end
        release_out();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [Q*OW-1:0] exp_a;
        set_vec_a();
        for (int k = 0; k < Q; k++) exp_a[k*OW +: OW] = exp_lin[k];
        apply_buses();
        in_valid = 1'b1;
        @(posedge clk); #1;
        wait_done(lat);
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL b2b_latency1: got %0d want 8", lat); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || lin_out_packed !== exp_a || sat_packed !== exp_sat) begin
                n_err++;
                $display("FAIL b2b_stall%0d: got ov=%b ir=%b lin=%h sat=%b want ov=1 ir=0 lin=%h sat=%b", c, out_valid, in_ready, lin_out_packed, sat_packed, exp_a, exp_sat);
            end
        end
        set_vec_d();
        apply_buses();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
        n_cmp++; if (lin_out_packed !== exp_a) begin n_err++; $display("FAIL b2b_hold: got %h want %h", lin_out_packed, exp_a); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept: got ir=%b want 0", in_ready); end
        wait_done(lat);
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL b2b_latency2: got %0d want 8", lat); end
        for (int k = 0; k < Q; k++) begin
            n_cmp++;
            if (lin_out_packed[k*OW +: OW] !== exp_lin[k] || sat_packed[k] !== exp_sat[k]) begin
                n_err++;
                $display("FAIL b2b_lane%0d: got lin=%h sat=%b want lin=%h sat=%b", k, lin_out_packed[k*OW +: OW], sat_packed[k], exp_lin[k], exp_sat[k]);
            end
        end
        release_out();
    endtask

    task automatic test_reset_midrun();
        int lat;
        set_vec_a();
        launch();
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (lin_out_packed !== {(Q*OW){1'b0}}) begin n_err++; $display("FAIL mid_rst_lin: got %h want 0", lin_out_packed); end
        n_cmp++; if (sat_packed !== 7'b0000000) begin n_err++; $display("FAIL mid_rst_sat: got %b want 0", sat_packed); end
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_hs: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        set_vec_d();
        launch();
        wait_done(lat);
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL mid_latency: got %0d want 8", lat); end
        for (int k = 0; k < Q; k++) begin
            n_cmp++;
            if (lin_out_packed[k*OW +: OW] !== exp_lin[k] || sat_packed[k] !== exp_sat[k]) begin
                n_err++;
                $display("FAIL mid_lane%0d: got lin=%h sat=%b want lin=%h sat=%b", k, lin_out_packed[k*OW +: OW], sat_packed[k], exp_lin[k], exp_sat[k]);
            end
        end
        release_out();
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        reset           = 1'b0;
        in_valid        = 1'b0;
        out_ready       = 1'b0;
        log_in_packed   = {(Q*LW){1'b0}};
        sign_in_packed  = 7'b0000000;
        valid_in_packed = 7'b0000000;
        test_reset();
        test_positive_terms();
        test_negative_terms();
        test_all_invalid();
        test_back_to_back();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
